// File: rtl/sa_2x2.sv
// 2x2 weight-stationary systolic MAC array.
// Weights shift down columns; activations move right, psums move down.
module sa_2x2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              weight_load,
  input  logic [DATA_W-1:0] w_in1,
  input  logic [DATA_W-1:0] w_in2,
  input  logic [DATA_W-1:0] act_in1,
  input  logic [DATA_W-1:0] act_in2,
  input  logic [DATA_W-1:0] psum_in1,
  input  logic [DATA_W-1:0] psum_in2,
  output logic [DATA_W-1:0] psum_out1,
  output logic [DATA_W-1:0] psum_out2
);

  logic [DATA_W-1:0] w11, w12, w21, w22;
  logic [DATA_W-1:0] a11, a21;
  logic [DATA_W-1:0] p11, p12, p21, p22;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w11 <= '0;
      w12 <= '0;
      w21 <= '0;
      w22 <= '0;
    end else if (weight_load) begin
      w11 <= w_in1;
      w21 <= w11;
      w12 <= w_in2;
      w22 <= w12;
    end
  end

  // a12/a22 would only feed a third column, so they are not kept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a11 <= '0;
      a21 <= '0;
      p11 <= '0;
      p12 <= '0;
      p21 <= '0;
      p22 <= '0;
    end else if (clear) begin
      a11 <= '0;
      a21 <= '0;
      p11 <= '0;
      p12 <= '0;
      p21 <= '0;
      p22 <= '0;
    end else begin
      a11 <= act_in1;
      a21 <= act_in2;
      p11 <= psum_in1 + w11 * act_in1;
      p21 <= p11 + w21 * act_in2;
      p12 <= psum_in2 + w12 * a11;
      p22 <= p12 + w22 * a21;
    end
  end

  assign psum_out1 = p21;
  assign psum_out2 = p22;

endmodule

// File: tb/tb_sa_2x2.sv
// Scoreboard bench for sa_2x2: column sums are predicted from
// the input history and popped when each edge has produced them.
module tb_sa_2x2;
  localparam int W = 8;
  localparam int N = 1024;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         weight_load;
  logic [W-1:0] w_in1, w_in2;
  logic [W-1:0] act_in1, act_in2;
  logic [W-1:0] psum_in1, psum_in2;
  logic [W-1:0] psum_out1, psum_out2;

  sa_2x2 #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .weight_load(weight_load),
    .w_in1      (w_in1),
    .w_in2      (w_in2),
    .act_in1    (act_in1),
    .act_in2    (act_in2),
    .psum_in1   (psum_in1),
    .psum_in2   (psum_in2),
    .psum_out1  (psum_out1),
    .psum_out2  (psum_out2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 2;
  int flush  = 2;

  logic [W-1:0] ha1 [N];
  logic [W-1:0] ha2 [N];
  logic [W-1:0] hp1 [N];
  logic [W-1:0] hp2 [N];
  logic [W-1:0] hw11[N];
  logic [W-1:0] hw12[N];
  logic [W-1:0] hw21[N];
  logic [W-1:0] hw22[N];
  logic [W-1:0] mw11, mw12, mw21, mw22;

  typedef struct {
    int           due;
    logic [W-1:0] v;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // terms sampled at or before the last clear/reset have been flushed
  function automatic logic [W-1:0] hv(input int t, input logic [W-1:0] v);
    return (t <= flush) ? '0 : v;
  endfunction

  task automatic step(input logic [W-1:0] a1, input logic [W-1:0] a2,
                      input logic [W-1:0] p1, input logic [W-1:0] p2,
                      input logic wl = 1'b0, input logic cl = 1'b0,
                      input logic [W-1:0] wi1 = '0,
                      input logic [W-1:0] wi2 = '0);
    int           k;
    logic [W-1:0] e1, e2;
    exp_t         e;
    k           = cyc + 1;
    act_in1     = a1;
    act_in2     = a2;
    psum_in1    = p1;
    psum_in2    = p2;
    weight_load = wl;
    clear       = cl;
    w_in1       = wi1;
    w_in2       = wi2;
    ha1[k]  = a1;
    ha2[k]  = a2;
    hp1[k]  = p1;
    hp2[k]  = p2;
    hw11[k] = mw11;
    hw12[k] = mw12;
    hw21[k] = mw21;
    hw22[k] = mw22;
    if (cl) begin
      e1 = '0;
      e2 = '0;
    end else begin
      e1 = hv(k-1, hp1[k-1]) + hw11[k-1] * hv(k-1, ha1[k-1])
         + hw21[k] * hv(k, ha2[k]);
      e2 = hv(k-1, hp2[k-1]) + hw12[k-1] * hv(k-2, ha1[k-2])
         + hw22[k] * hv(k-1, ha2[k-1]);
    end
    q1.push_back('{due: k, v: e1});
    q2.push_back('{due: k, v: e2});
    if (cl) flush = k;
    if (wl) begin
      mw21 = mw11;
      mw11 = wi1;
      mw22 = mw12;
      mw12 = wi2;
    end
    @(posedge clk);
    cyc = k;
    #1;
    while (q1.size() > 0 && q1[0].due <= cyc) begin
      e = q1.pop_front();
      chk("col1", psum_out1, e.v);
    end
    while (q2.size() > 0 && q2[0].due <= cyc) begin
      e = q2.pop_front();
      chk("col2", psum_out2, e.v);
    end
  endtask

  task automatic load2(input logic [W-1:0] x1, input logic [W-1:0] x2,
                       input logic [W-1:0] y1, input logic [W-1:0] y2);
    step('0, '0, '0, '0, 1'b1, 1'b0, x1, x2);
    step('0, '0, '0, '0, 1'b1, 1'b0, y1, y2);
  endtask

  task automatic rand_steps(input int n, input bit wl_rand);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(255), $urandom_range(255),
           $urandom_range(255), $urandom_range(255),
           wl_rand ? 1'($urandom_range(1)) : 1'b0, 1'b0,
           $urandom_range(255), $urandom_range(255));
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      ha1[i]  = '0;
      ha2[i]  = '0;
      hp1[i]  = '0;
      hp2[i]  = '0;
      hw11[i] = '0;
      hw12[i] = '0;
      hw21[i] = '0;
      hw22[i] = '0;
    end
    {mw11, mw12, mw21, mw22} = '0;
    rst         = 1'b0;
    clear       = 1'b0;
    weight_load = 1'b0;
    {w_in1, w_in2, act_in1, act_in2, psum_in1, psum_in2} = '0;
    #12;
    chk("rst_out1", psum_out1, 8'd0);
    chk("rst_out2", psum_out2, 8'd0);
    rst = 1'b1;

    // GEMM with top weights 3,4 and bottom weights 1,2
    load2(8'd1, 8'd2, 8'd3, 8'd4);
    step(8'd1, 8'd0, 8'd0, 8'd0);
    step(8'd2, 8'd3, 8'd0, 8'd0);
    chk("gemm_o1_e2", psum_out1, 8'd6);
    step(8'd0, 8'd4, 8'd0, 8'd0);
    chk("gemm_o1_e3", psum_out1, 8'd10);
    chk("gemm_o2_e3", psum_out2, 8'd10);
    step(8'd0, 8'd0, 8'd0, 8'd0);
    chk("gemm_o1_e4", psum_out1, 8'd0);
    chk("gemm_o2_e4", psum_out2, 8'd16);

    // psum injection
    load2(8'd1, 8'd1, 8'd1, 8'd1);
    step(8'd2, 8'd0, 8'd5, 8'd0);
    step(8'd0, 8'd0, 8'd0, 8'd0);
    chk("inject", psum_out1, 8'd7);

    // wraparound: 255*255 mod 256
    load2(8'd0, 8'd0, 8'd255, 8'd0);
    step(8'd255, 8'd0, 8'd0, 8'd0);
    step(8'd0, 8'd0, 8'd0, 8'd0);
    chk("wrap", psum_out1, 8'd1);

    // random stream on fixed weights, then clear mid-stream
    load2($urandom_range(255), $urandom_range(255),
          $urandom_range(255), $urandom_range(255));
    rand_steps(20, 1'b0);
    step(8'd9, 8'd9, 8'd9, 8'd9, 1'b0, 1'b1);
    chk("clear_o1", psum_out1, 8'd0);
    chk("clear_o2", psum_out2, 8'd0);
    rand_steps(20, 1'b0);

    // clear together with a weight shift
    step(8'd3, 8'd3, 8'd3, 8'd3, 1'b1, 1'b1, 8'd7, 8'd11);
    rand_steps(10, 1'b0);

    // weights shifting while activations stream
    rand_steps(60, 1'b1);

    // asynchronous reset between edges
    #2 rst = 1'b0;
    #1;
    chk("arst_o1", psum_out1, 8'd0);
    chk("arst_o2", psum_out2, 8'd0);
    {mw11, mw12, mw21, mw22} = '0;
    flush = cyc;
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(8'd5, 8'd7, 8'd0, 8'd0);
      chk("zero_w_o1", psum_out1, 8'd0);
      chk("zero_w_o2", psum_out2, 8'd0);
    end
    rand_steps(10, 1'b1);

    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0",
               q1.size() + q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_2x2.md
Name: sa_2x2

Overview:
- 2x2 weight-stationary systolic array of four multiply-accumulate processing elements (PEs).
- Weights are shifted in down each column and then held. Activations flow left-to-right along rows; partial sums flow top-to-bottom along columns.
- It is the compute core fed by skewed activation streams. It produces one column-sum per column per cycle.

Parameters:
- DATA_W, 8, width of weights, activations and partial sums. All arithmetic is modulo 2^DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of activation and psum pipeline registers; weights retained.
- weight_load  in  1  when high, the weight column shift registers advance.
- w_in1  in  DATA_W  weight entering column 1 (top, PE11).
- w_in2  in  DATA_W  weight entering column 2 (top, PE12).
- act_in1  in  DATA_W  activation entering row 1 (left, PE11).
- act_in2  in  DATA_W  activation entering row 2 (left, PE21).
- psum_in1  in  DATA_W  partial sum entering the top of column 1.
- psum_in2  in  DATA_W  partial sum entering the top of column 2.
- psum_out1  out  DATA_W  bottom of column 1 (PE21 psum register).
- psum_out2  out  DATA_W  bottom of column 2 (PE22 psum register).

Behaviour:
- Each PE has three registers: weight w, activation a, psum p. Indices: r = row, c = column.
- Reset (rst=0, asynchronous): all weights, activations and psums go to 0, so both outputs read 0. Reset mid-operation discards everything, including loaded weights.
- Weight load, on each rising edge with weight_load=1:
  - w11<=w_in1, w21<=w11; w12<=w_in2, w22<=w12.
  - Loading two consecutive cycles with (x, y) leaves top-row PE=y and bottom-row PE=x.
  - With weight_load=0, weights hold.
- MAC, every rising edge regardless of weight_load (uses the current weight register values):
  - Activations: a11<=act_in1; a12<=a11; a21<=act_in2; a22<=a21.
  - Psums:
    - p11<=psum_in1 + w11*act_in1
    - p21<=p11 + w21*act_in2
    - p12<=psum_in2 + w12*a11
    - p22<=p12 + w22*a21
- Outputs: psum_out1=p21 and psum_out2=p22, registered with no combinational path from inputs.
- Latency from an input sample to its output: column 1 = 2 cycles; column 2 = 3 cycles.
- Input skew: the caller skews row 2 one cycle behind row 1.
- Arithmetic: the product is truncated to DATA_W and the add wraps modulo 2^DATA_W (unsigned, no saturation).
- clear=1 at an edge:
  - all a and p registers go to 0 (overrides the MAC update); weights unaffected.
  - If weight_load is also high, the weight shift still occurs.

Test Plan:
- Reset: assert rst=0 mid-run with nonzero weights and psums → psum_out1=psum_out2=0 immediately (asynchronous); weights read back as 0 via a subsequent MAC.
- Weight load + GEMM, step 1: weight_load for 2 cycles with (w_in1,w_in2)=(1,2) then (3,4), giving top weights 3,4 and bottom weights 1,2.
- Weight load + GEMM, step 2: drive (act_in1,act_in2) on consecutive edges as (1,0),(2,3),(0,4),(0,0), with psum_in=0.
- Weight load + GEMM, expected: psum_out1 = 6, 10, 0 after edges 2, 3, 4; psum_out2 = 10, 16 after edges 3, 4.
- Psum injection: weights all 1, psum_in1=5, act_in1=2, act_in2=0 → psum_out1=7 two edges later.
- Wraparound: w11=255, act_in1=255, others 0 → p11 = 1 (65025 mod 256), propagating to psum_out1=1.
- Clear: mid-stream clear=1 for one edge → psum_out1/2 read 0 after the next edge; next stream uses the original weights unchanged.
- Load during MAC: weight_load high while activations stream → MACs use weight values present at each edge; weights shift exactly one position per loaded edge.
